// File: rtl/hex_display_arbiter_if.sv
// Signal bundle between the PIO/board side and hex_display_arbiter.
// master drives host word, switches and keys; slave (the arbiter) drives the display outputs.
interface hex_display_arbiter_if;
    logic [31:0] host_hex;
    logic [15:0] switches;
    logic [3:0]  button_n;
    logic [55:0] hex_seg;
    logic        owner;
    logic        host_pending;
    logic [31:0] display_word;

    modport master (
        output host_hex, switches, button_n,
        input  hex_seg, owner, host_pending, display_word
    );

    modport slave (
        input  host_hex, switches, button_n,
        output hex_seg, owner, host_pending, display_word
    );
endinterface

// File: rtl/hex_display_arbiter.sv
// Arbitrates the 8-digit seven-segment bank between the PCIe host word and local switches/keys.
// Optional HEX_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is never blanked).
module hex_display_arbiter #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned LOCAL_TIMEOUT   = 250000000,
    parameter int unsigned CNT_W           = 28
) (
    input  logic                  clk,
    input  logic                  reset,
    hex_display_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {ST_HOST, ST_LOCAL, ST_HANDBACK} state_t;

    logic [3:0]       btn_s1, btn_s2, key_deb, key_armed, press;
    logic [CNT_W-1:0] deb_cnt [4];
    logic [31:0]      host_q, local_reg, local_reg_d, display_word_q, display_d;
    logic [15:0]      sw_q;
    logic             host_pending_q, host_pending_d, owner_q;
    logic             host_chg, sw_chg;
    logic [CNT_W-1:0] idle_cnt, idle_d;
    logic [55:0]      seg_q, seg_d;
    state_t           state, state_d;

    // A key is armed only after it has been seen released, so a key held
    // through reset release cannot produce a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1    <= '0;
            btn_s2    <= '0;
            key_deb   <= '1;
            key_armed <= '0;
            press     <= '0;
            for (int unsigned k = 0; k < 4; k++) deb_cnt[k] <= '0;
        end else begin
            btn_s1 <= bus.button_n;
            btn_s2 <= btn_s1;
            for (int unsigned k = 0; k < 4; k++) begin
                press[k] <= 1'b0;
                if (btn_s2[k] == key_deb[k]) begin
                    deb_cnt[k] <= '0;
                    if (btn_s2[k]) key_armed[k] <= 1'b1;
                end else if (deb_cnt[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_cnt[k] <= '0;
                    key_deb[k] <= btn_s2[k];
                    press[k]   <= key_armed[k] & ~btn_s2[k];
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign host_chg = (bus.host_hex != host_q);
    assign sw_chg   = (bus.switches != sw_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_HOST;
            owner_q        <= 1'b0;
            host_q         <= '0;
            sw_q           <= '0;
            local_reg      <= '0;
            display_word_q <= '0;
            host_pending_q <= 1'b0;
            idle_cnt       <= '0;
            seg_q          <= {8{7'h40}};
        end else begin
            state          <= state_d;
            owner_q        <= (state_d == ST_LOCAL);
            host_q         <= bus.host_hex;
            sw_q           <= bus.switches;
            local_reg      <= local_reg_d;
            display_word_q <= display_d;
            host_pending_q <= host_pending_d;
            idle_cnt       <= idle_d;
            seg_q          <= seg_d;
        end
    end

    always_comb begin
        state_d        = state;
        display_d      = display_word_q;
        local_reg_d    = local_reg;
        host_pending_d = host_pending_q;
        idle_d         = idle_cnt;
        unique case (state)
            ST_HOST: begin
                display_d = bus.host_hex;
                idle_d    = '0;
                if (press[0]) begin
                    state_d     = ST_LOCAL;
                    local_reg_d = {16'h0, bus.switches};
                end
            end
            ST_LOCAL: begin
                display_d = local_reg;
                if (host_chg) host_pending_d = 1'b1;
                idle_d = ((|press) || sw_chg) ? '0 : idle_cnt + 1'b1;
                // Leaving takes priority over a reload in the same cycle.
                if (press[0] || (idle_cnt == CNT_W'(LOCAL_TIMEOUT - 1)))
                    state_d = ST_HANDBACK;
                else if (press[1])
                    local_reg_d = {16'h0, bus.switches};
            end
            ST_HANDBACK: begin
                display_d      = bus.host_hex;
                host_pending_d = 1'b0;
                idle_d         = '0;
                state_d        = ST_HOST;
            end
            default: state_d = ST_HOST;
        endcase
    end

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        seg_d = '1;
        for (int unsigned d = 0; d < 8; d++)
            seg_d[7*d +: 7] = seg7(display_word_q[4*d +: 4]);
`ifdef HEX_LEADING_ZERO_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            // Scan from digit 7 down to digit 1; blank while still in the leading zero run.
            for (int unsigned i = 0; i < 7; i++) begin
                if (display_word_q[4*(7-i) +: 4] != 4'h0) lead = 1'b0;
                if (lead) seg_d[7*(7-i) +: 7] = 7'h7F;
            end
        end
`endif
    end

    assign bus.hex_seg      = seg_q;
    assign bus.owner        = owner_q;
    assign bus.host_pending = host_pending_q;
    assign bus.display_word = display_word_q;
endmodule
